fpu_mul_sched: RTL and testbench

- Shares one `fpuprod64` multiplier (fixed 2-register pipeline) among NREQ requesters.
- Arbitrates issue round-robin and tracks in-flight ops in a shadow pipeline.
- Drives the multiplier's late-stage `pookg` select in step with the op, and buffers results in a credit-protected FIFO, because the multiplier cannot stall.
- Sits between the FP issue ports and the shared multiplier in the FPU cluster.

---
 rtl/fpu_mul_sched_if.sv | 27 ++
 rtl/fpu_mul_sched.sv | 190 +++++++++++++++++++
 tb/tb_fpu_mul_sched.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_mul_sched_if.sv
// Request/response bundle between the FP issue ports and the multiplier scheduler.
// The master side is the issue/consume logic; the slave side is the scheduler.
interface fpu_mul_sched_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*64-1:0] req_a;
   logic [NREQ*64-1:0] req_b;
   logic [NREQ-1:0]    req_rnd;
   logic [NREQ-1:0]    req_pookg;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [63:0]        rsp_res;
   logic [IDW-1:0]     rsp_id;

   modport master (
      output req_valid, req_a, req_b, req_rnd, req_pookg, rsp_ready,
      input  req_ready, rsp_valid, rsp_res, rsp_id
   );

   modport slave (
      input  req_valid, req_a, req_b, req_rnd, req_pookg, rsp_ready,
      output req_ready, rsp_valid, rsp_res, rsp_id
   );
endinterface

// File: rtl/fpu_mul_sched.sv
// Scheduler sharing one non-stallable fixed-latency multiplier among NREQ
// requesters: round-robin issue, a shadow pipeline that follows each op
// through the multiplier, and a credit-protected result FIFO.

// Property checker: the credit rule must keep the FIFO from overflowing and
// the grant vector must never carry more than one bit.
module fpu_mul_sched_chk #(
   parameter int NREQ  = 4,
   parameter int DEPTH = 4,
   parameter int CW    = 3
) (
   input logic            clk,
   input logic            rst,
   input logic            push,
   input logic            pop,
   input logic [CW-1:0]   cnt,
   input logic [NREQ-1:0] ready
);
   no_overflow: assert property (@(posedge clk) disable iff (!rst)
      !(push && !pop && (cnt == CW'(DEPTH))));

   grant_onehot: assert property (@(posedge clk) disable iff (!rst)
      $onehot0(ready));
endmodule

module fpu_mul_sched #(
   parameter int NREQ  = 4,
   parameter int LAT   = 2,
   parameter int DEPTH = 4,
   parameter int IDW   = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   fpu_mul_sched_if.slave       bus,
   output logic [63:0]          mul_a,
   output logic [63:0]          mul_b,
   output logic                 mul_rnd,
   output logic                 mul_pookg,
   input  logic [63:0]          mul_res,
   output logic                 busy
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   // arbitration state
   logic [IDW-1:0]  rr_ptr_r;
   logic            grant_v_s;
   logic [IDW-1:0]  grant_id_s;
   logic            credit_ok_s;
   int              inflight_s;
   int              occ_s;

   // shadow pipeline, one entry per multiplier register stage
   logic [LAT-1:0]  sh_v_r;
   logic [LAT-1:0]  sh_pk_r;
   logic [IDW-1:0]  sh_id_r [LAT];

   // result FIFO
   logic [63:0]     mem_res_r [DEPTH];
   logic [IDW-1:0]  mem_id_r  [DEPTH];
   logic [AW-1:0]   wptr_r;
   logic [AW-1:0]   rptr_r;
   logic [CW-1:0]   fifo_cnt_r;
   logic            push_s;
   logic            pop_s;

   // per-requester operand views
   logic [63:0]     op_a_s [NREQ];
   logic [63:0]     op_b_s [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign op_a_s[g] = bus.req_a[64*g +: 64];
      assign op_b_s[g] = bus.req_b[64*g +: 64];
   end

   assign push_s = sh_v_r[LAT-1];
   assign pop_s  = (fifo_cnt_r != {CW{1'b0}}) && bus.rsp_ready;

   // Credit: everything in the multiplier plus everything buffered must fit
   // in the FIFO, counting a same-cycle pop as freeing a slot. Reset blocks issue.
   always_comb begin
      inflight_s  = $countones(sh_v_r);
      occ_s       = int'(fifo_cnt_r) + inflight_s - int'(pop_s);
      credit_ok_s = rst && (occ_s < DEPTH);
   end

   // Round-robin pick: first valid requester after rr_ptr, cyclically.
   always_comb begin
      int   idx_v;
      logic hit_v;
      idx_v      = 32'sd0;
      hit_v      = 1'b0;
      grant_v_s  = 1'b0;
      grant_id_s = {IDW{1'b0}};
      for (int k = 1; k <= NREQ; k++) begin
         idx_v      = (int'(rr_ptr_r) + k) % NREQ;
         hit_v      = credit_ok_s && !grant_v_s && bus.req_valid[IDW'(idx_v)];
         grant_id_s = hit_v ? IDW'(idx_v) : grant_id_s;
         grant_v_s  = grant_v_s | hit_v;
      end
   end

   // Grant vector and operand mux toward the multiplier; zero when idle.
   always_comb begin
      if (grant_v_s) begin
         bus.req_ready = NREQ'(1'b1) << grant_id_s;
         mul_a         = op_a_s[grant_id_s];
         mul_b         = op_b_s[grant_id_s];
         mul_rnd       = bus.req_rnd[grant_id_s];
      end else begin
         bus.req_ready = {NREQ{1'b0}};
         mul_a         = 64'd0;
         mul_b         = 64'd0;
         mul_rnd       = 1'b0;
      end
   end

   // Round-robin pointer follows the last granted requester.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr_r <= IDW'(NREQ - 1);
      end else if (grant_v_s) begin
         rr_ptr_r <= grant_id_s;
      end
   end

   // Shadow pipeline shifts every cycle in lockstep with the multiplier,
   // since the multiplier itself never stalls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sh_v_r  <= {LAT{1'b0}};
         sh_pk_r <= {LAT{1'b0}};
         for (int i = 0; i < LAT; i++) begin
            sh_id_r[i] <= {IDW{1'b0}};
         end
      end else begin
         sh_v_r[0]  <= grant_v_s;
         sh_pk_r[0] <= grant_v_s & bus.req_pookg[grant_id_s];
         sh_id_r[0] <= grant_id_s;
         for (int i = 1; i < LAT; i++) begin
            sh_v_r[i]  <= sh_v_r[i-1];
            sh_pk_r[i] <= sh_pk_r[i-1];
            sh_id_r[i] <= sh_id_r[i-1];
         end
      end
   end

   // Result FIFO: capture the multiplier output when the last shadow stage
   // is valid, pop on handshake; push and pop together leave the count alone.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_r     <= {AW{1'b0}};
         rptr_r     <= {AW{1'b0}};
         fifo_cnt_r <= {CW{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_res_r[i] <= 64'd0;
            mem_id_r[i]  <= {IDW{1'b0}};
         end
      end else begin
         if (push_s) begin
            mem_res_r[wptr_r] <= mul_res;
            mem_id_r[wptr_r]  <= sh_id_r[LAT-1];
            wptr_r            <= wptr_r + AW'(1'b1);
         end
         if (pop_s) begin
            rptr_r <= rptr_r + AW'(1'b1);
         end
         fifo_cnt_r <= fifo_cnt_r + CW'(push_s) - CW'(pop_s);
      end
   end

   assign mul_pookg     = sh_v_r[LAT-1] & sh_pk_r[LAT-1];
   assign bus.rsp_valid = (fifo_cnt_r != {CW{1'b0}});
   assign bus.rsp_res   = mem_res_r[rptr_r];
   assign bus.rsp_id    = mem_id_r[rptr_r];
   assign busy          = (|sh_v_r) || (fifo_cnt_r != {CW{1'b0}});

   fpu_mul_sched_chk #(
      .NREQ  (NREQ),
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_chk (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .pop   (pop_s),
      .cnt   (fifo_cnt_r),
      .ready (bus.req_ready)
   );
endmodule

// File: tb/tb_fpu_mul_sched.sv
// Directed bench for fpu_mul_sched with a stand-in multiplier that returns
// the XOR of its operands two register stages later.
module tb_fpu_mul_sched;
   logic        clk;
   logic        rst;
   logic [63:0] mul_a;
   logic [63:0] mul_b;
   logic        mul_rnd;
   logic        mul_pookg;
   logic [63:0] mul_res;
   logic        busy;

   logic [63:0] m1_r;
   logic [63:0] m2_r;

   logic [63:0] a_v  [4];
   logic [63:0] b_v  [4];
   logic [3:0]  rnd_v;
   logic [3:0]  pk_v;

   int n_tests;
   int n_fail;

   fpu_mul_sched_if #(.NREQ(4), .IDW(2)) bus ();

   fpu_mul_sched #(.NREQ(4), .LAT(2), .DEPTH(4), .IDW(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_rnd   (mul_rnd),
      .mul_pookg (mul_pookg),
      .mul_res   (mul_res),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // stand-in multiplier: two register stages, no reset
   always @(posedge clk) begin
      m1_r <= mul_a ^ mul_b;
      m2_r <= m1_r;
   end
   assign mul_res = m2_r;

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "FAIL watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pack_ops();
      bus.req_a     = {a_v[3], a_v[2], a_v[1], a_v[0]};
      bus.req_b     = {b_v[3], b_v[2], b_v[1], b_v[0]};
      bus.req_rnd   = rnd_v;
      bus.req_pookg = pk_v;
   endtask

   task automatic set_op(input logic [1:0] i, input logic [63:0] a, input logic [63:0] b,
                         input logic rnd, input logic pk);
      a_v[i]   = a;
      b_v[i]   = b;
      rnd_v[i] = rnd;
      pk_v[i]  = pk;
      pack_ops();
   endtask

   // Reset for two edges; returns at the start of the first cycle after release.
   task automatic do_reset();
      rst           = 1'b0;
      bus.req_valid = 4'b0000;
      bus.rsp_ready = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   initial begin
      logic [63:0] q [$];
      logic [63:0] exp_v;
      int          n_grant;
      int          n_resp;

      n_tests = 0;
      n_fail  = 0;
      clk     = 1'b0;
      rst     = 1'b0;
      rnd_v   = 4'b0000;
      pk_v    = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         a_v[i] = 64'd0;
         b_v[i] = 64'd0;
      end
      pack_ops();
      bus.req_valid = 4'b1111;
      bus.rsp_ready = 1'b0;

      // ---- reset state, with requests pending ----
      tick();
      settle();
      chk("rst_req_ready", 64'(bus.req_ready), 64'h0);
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
      chk("rst_busy",      64'(busy),          64'h0);
      chk("rst_mul_pookg", 64'(mul_pookg),     64'h0);
      chk("rst_mul_a",     mul_a,              64'h0);
      tick();
      bus.req_valid = 4'b0000;
      rst = 1'b1;

      // ---- single op from requester 0 ----
      tick();
      tick();
      set_op(2'd0, 64'h0000_0000_0000_00F0, 64'h0000_0000_0000_000F, 1'b0, 1'b0);
      bus.req_valid = 4'b0001;
      settle();
      chk("t1_grant",      64'(bus.req_ready), 64'h1);
      chk("t1_mul_a",      mul_a,              64'hF0);
      chk("t1_mul_b",      mul_b,              64'h0F);
      chk("t1_busy_issue", 64'(busy),          64'h0);
      tick();
      bus.req_valid = 4'b0000;
      settle();
      chk("t1_busy_p1",  64'(busy),          64'h1);
      chk("t1_rsp_p1",   64'(bus.rsp_valid), 64'h0);
      chk("t1_idle_a",   mul_a,              64'h0);
      tick();
      settle();
      chk("t1_busy_p2",  64'(busy),          64'h1);
      chk("t1_rsp_p2",   64'(bus.rsp_valid), 64'h0);
      tick();
      bus.rsp_ready = 1'b1;
      settle();
      chk("t1_rsp_p3",   64'(bus.rsp_valid), 64'h1);
      chk("t1_res",      bus.rsp_res,        64'hFF);
      chk("t1_id",       64'(bus.rsp_id),    64'h0);
      chk("t1_busy_p3",  64'(busy),          64'h1);
      tick();
      bus.rsp_ready = 1'b0;
      settle();
      chk("t1_rsp_done",  64'(bus.rsp_valid), 64'h0);
      chk("t1_busy_done", 64'(busy),          64'h0);
      tick();

      // ---- four requesters valid from the first cycle after reset ----
      do_reset();
      set_op(2'd0, 64'h0123_4567_89AB_CDEF, 64'h0000_0000_0000_FFFF, 1'b0, 1'b0);
      set_op(2'd1, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 1'b0);
      set_op(2'd2, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
      set_op(2'd3, 64'h0000_0000_DEAD_BEEF, 64'h0000_0000_0000_0000, 1'b0, 1'b0);
      bus.rsp_ready = 1'b1;
      bus.req_valid = 4'b1111;
      for (int c = 0; c < 7; c++) begin
         settle();
         if (c < 4) begin
            chk("t2_grant", 64'(bus.req_ready), 64'h1 << c);
         end
         if (c >= 3) begin
            exp_v = a_v[2'(c - 3)] ^ b_v[2'(c - 3)];
            chk("t2_rsp_valid", 64'(bus.rsp_valid), 64'h1);
            chk("t2_rsp_id",    64'(bus.rsp_id),    64'(c - 3));
            chk("t2_rsp_res",   bus.rsp_res,        exp_v);
         end else begin
            chk("t2_rsp_early", 64'(bus.rsp_valid), 64'h0);
         end
         tick();
         if (c < 4) begin
            bus.req_valid[2'(c)] = 1'b0;
         end
      end
      settle();
      chk("t2_busy_end", 64'(busy), 64'h0);
      tick();

      // ---- credit limit: consumer stalled, requester 1 always valid ----
      do_reset();
      n_grant       = 0;
      n_resp        = 0;
      bus.req_valid = 4'b0010;
      for (int k = 0; k < 24; k++) begin
         set_op(2'd1, 64'h100 + 64'(k), 64'h0000_0000_FF00_0000, 1'b0, 1'b0);
         bus.rsp_ready = (k == 8) || (k >= 12);
         if (k == 18) begin
            bus.req_valid = 4'b0000;
         end
         settle();
         if (k < 12) begin
            chk("t3_grant", 64'(bus.req_ready), ((k < 4) || (k == 8)) ? 64'h2 : 64'h0);
         end
         if (bus.req_ready[1]) begin
            q.push_back(a_v[1] ^ b_v[1]);
            n_grant++;
         end
         if (bus.rsp_valid && bus.rsp_ready) begin
            n_resp++;
            chk("t3_rsp_expected", 64'(q.size() != 0), 64'h1);
            if (q.size() != 0) begin
               exp_v = q.pop_front();
               chk("t3_rsp_res", bus.rsp_res,     exp_v);
               chk("t3_rsp_id",  64'(bus.rsp_id), 64'h1);
            end
         end
         tick();
      end
      bus.rsp_ready = 1'b0;
      settle();
      chk("t3_busy_end",   64'(busy),     64'h0);
      chk("t3_queue_left", 64'(q.size()), 64'h0);
      chk("t3_resp_count", 64'(n_resp),   64'(n_grant));
      tick();

      // ---- pookg follows its op to the result stage ----
      do_reset();
      bus.rsp_ready = 1'b1;
      set_op(2'd2, 64'h2222, 64'h0000, 1'b0, 1'b1);
      set_op(2'd3, 64'h3333, 64'h0000, 1'b1, 1'b0);
      bus.req_valid = 4'b0100;
      settle();
      chk("t4_grant2",    64'(bus.req_ready), 64'h4);
      chk("t4_rnd_t",     64'(mul_rnd),       64'h0);
      chk("t4_pookg_t",   64'(mul_pookg),     64'h0);
      tick();
      bus.req_valid = 4'b1000;
      settle();
      chk("t4_grant3",    64'(bus.req_ready), 64'h8);
      chk("t4_rnd_t1",    64'(mul_rnd),       64'h1);
      chk("t4_pookg_t1",  64'(mul_pookg),     64'h0);
      tick();
      bus.req_valid = 4'b0000;
      settle();
      chk("t4_pookg_t2",  64'(mul_pookg),     64'h1);
      tick();
      settle();
      chk("t4_pookg_t3",  64'(mul_pookg),     64'h0);
      chk("t4_rsp_id2",   64'(bus.rsp_id),    64'h2);
      chk("t4_rsp_res2",  bus.rsp_res,        64'h2222);
      tick();
      settle();
      chk("t4_rsp_id3",   64'(bus.rsp_id),    64'h3);
      chk("t4_rsp_res3",  bus.rsp_res,        64'h3333);
      tick();

      // ---- reset with ops in flight and buffered ----
      do_reset();
      set_op(2'd0, 64'h55, 64'h00, 1'b0, 1'b1);
      bus.req_valid = 4'b0001;
      for (int k = 0; k < 4; k++) begin
         settle();
         chk("t5_fill_grant", 64'(bus.req_ready), 64'h1);
         tick();
      end
      bus.req_valid = 4'b0000;
      settle();
      chk("t5_pre_rsp",   64'(bus.rsp_valid), 64'h1);
      chk("t5_pre_busy",  64'(busy),          64'h1);
      chk("t5_pre_pookg", 64'(mul_pookg),     64'h1);
      #2;
      rst = 1'b0;
      bus.req_valid = 4'b0011;
      #1;
      chk("t5_rst_rsp",   64'(bus.rsp_valid), 64'h0);
      chk("t5_rst_busy",  64'(busy),          64'h0);
      chk("t5_rst_pookg", 64'(mul_pookg),     64'h0);
      chk("t5_rst_ready", 64'(bus.req_ready), 64'h0);
      tick();
      tick();
      rst = 1'b1;
      set_op(2'd0, 64'hAAAA, 64'h0F0F, 1'b0, 1'b0);
      set_op(2'd1, 64'hBBBB, 64'h0000, 1'b0, 1'b0);
      settle();
      chk("t5_first_grant", 64'(bus.req_ready), 64'h1);
      tick();
      bus.req_valid = 4'b0000;
      for (int k = 1; k < 6; k++) begin
         bus.rsp_ready = (k >= 3);
         settle();
         if (k == 3) begin
            chk("t5_new_rsp", 64'(bus.rsp_valid), 64'h1);
            chk("t5_new_res", bus.rsp_res,        64'hA5A5);
            chk("t5_new_id",  64'(bus.rsp_id),    64'h0);
         end else begin
            chk("t5_no_stale", 64'(bus.rsp_valid), 64'h0);
         end
         tick();
      end
      settle();
      chk("t5_busy_end", 64'(busy), 64'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
